// File: rtl/cmd_fifo_writer_if.sv
// cmd_fifo_writer_if: request handshake and FIFO write port bundle for cmd_fifo_writer.
interface cmd_fifo_writer_if #(
    parameter int WIDTH     = 16,
    parameter int ADDR_W    = 12,
    parameter int REQ_LEN_W = 8
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_wr;
    logic [ADDR_W-1:0]    req_addr;
    logic [REQ_LEN_W-1:0] req_len;
    logic                 busy;
    logic                 done;
    logic                 WrEn;
    logic [WIDTH-1:0]     Data;
    logic                 Full;
    logic [15:0]          stall_cnt;
    modport master (
        output req_valid, req_wr, req_addr, req_len, Full,
        input  req_ready, busy, done, WrEn, Data, stall_cnt
    );
    modport slave (
        input  req_valid, req_wr, req_addr, req_len, Full,
        output req_ready, busy, done, WrEn, Data, stall_cnt
    );
endinterface

// File: rtl/cmd_fifo_writer.sv
// cmd_fifo_writer: splits transfer requests into aligned bursts and pushes one command word per burst.
// Optional Full-stall counter enabled by CMD_FIFO_WRITER_STALL_CNT_EN.
module cmd_fifo_writer #(
    parameter int WIDTH     = 16,
    parameter int ADDR_W    = 12,
    parameter int LEN_W     = 3,
    parameter int MAX_BURST = 8,
    parameter int REQ_LEN_W = 8
) (
    input logic WrClk,
    input logic Reset,
    cmd_fifo_writer_if.slave bus
);
    if (WIDTH != 1 + ADDR_W + LEN_W) begin : g_bad_width
        $error("cmd_fifo_writer: WIDTH must equal 1+ADDR_W+LEN_W");
    end
    if (MAX_BURST < 1 || (MAX_BURST & (MAX_BURST - 1)) != 0 || MAX_BURST > (1 << LEN_W)) begin : g_bad_burst
        $error("cmd_fifo_writer: MAX_BURST must be a power of two no larger than 2**LEN_W");
    end
    localparam int CW = (REQ_LEN_W > LEN_W ? REQ_LEN_W : LEN_W) + 1;
    typedef enum logic {IDLE, SEND} state_t;
    state_t               state, state_d;
    logic                 op;
    logic [ADDR_W-1:0]    cur_addr;
    logic [REQ_LEN_W-1:0] remaining;
    logic                 done_zero;
    logic [CW-1:0]        room, chunk;
    logic                 accept, push, last;
    // Beats left before the next MAX_BURST-aligned boundary bound each burst.
    assign room   = CW'(MAX_BURST) - CW'(cur_addr % MAX_BURST);
    assign chunk  = (CW'(remaining) < room) ? CW'(remaining) : room;
    assign last   = chunk == CW'(remaining);
    assign accept = (state == IDLE) && bus.req_valid;
    always_comb begin
        push          = (state == SEND) && !bus.Full;
        state_d       = (state == IDLE) ? ((accept && bus.req_len != '0) ? SEND : IDLE)
                                        : ((push && last) ? IDLE : SEND);
        bus.req_ready = state == IDLE;
        bus.busy      = state == SEND;
        bus.WrEn      = push;
        bus.done      = done_zero || (push && last);
        bus.Data      = (state == SEND) ? {op, cur_addr, LEN_W'(chunk - 1'b1)} : '0;
    end
    always_ff @(posedge WrClk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            op        <= 1'b0;
            cur_addr  <= '0;
            remaining <= '0;
            done_zero <= 1'b0;
        end else begin
            state     <= state_d;
            done_zero <= accept && bus.req_len == '0;
            if (accept) begin
                op        <= bus.req_wr;
                cur_addr  <= bus.req_addr;
                remaining <= bus.req_len;
            end else if (push) begin
                cur_addr  <= cur_addr + ADDR_W'(chunk);
                remaining <= remaining - REQ_LEN_W'(chunk);
            end
        end
    end
`ifdef CMD_FIFO_WRITER_STALL_CNT_EN
    logic [15:0] stall_q;
    always_ff @(posedge WrClk or posedge Reset) begin
        if (Reset) stall_q <= '0;
        else if (state == SEND && bus.Full && stall_q != 16'hFFFF) stall_q <= stall_q + 1'b1;
    end
    assign bus.stall_cnt = stall_q;
`else
    assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_cmd_fifo_writer.sv
// tb_cmd_fifo_writer: directed checks of burst splitting, Full stalls, reset abort and back-to-back requests.
module tb_cmd_fifo_writer;
    logic WrClk = 1'b0;
    logic Reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    cmd_fifo_writer_if #(.WIDTH(16), .ADDR_W(12), .REQ_LEN_W(8)) bus ();
    cmd_fifo_writer dut (.WrClk(WrClk), .Reset(Reset), .bus(bus));
    always #5 WrClk = ~WrClk;
`ifdef CMD_FIFO_WRITER_STALL_CNT_EN
    localparam logic [15:0] STALL_EXP = 16'd5;
`else
    localparam logic [15:0] STALL_EXP = 16'd0;
`endif
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic cyc();
        @(negedge WrClk);
    endtask
    task automatic req(input logic v, input logic wr, input logic [11:0] a, input logic [7:0] l);
        bus.req_valid = v;
        bus.req_wr    = wr;
        bus.req_addr  = a;
        bus.req_len   = l;
    endtask
    task automatic push_chk(input string tag, input logic [15:0] d, input logic dn);
        chk({tag, "_wren"}, 32'(bus.WrEn), 32'd1);
        chk({tag, "_data"}, 32'(bus.Data), 32'(d));
        chk({tag, "_done"}, 32'(bus.done), 32'(dn));
    endtask
    logic [15:0] exp_q [5] = '{16'h801C, 16'h8047, 16'h8087, 16'h80C7, 16'h8100};
    int k;
    initial begin
        req(1'b0, 1'b0, 12'h0, 8'h0);
        bus.Full = 1'b0;
        #2;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_wren", 32'(bus.WrEn), 32'd0);
        chk("rst_data", 32'(bus.Data), 32'd0);
        chk("rst_stall", 32'(bus.stall_cnt), 32'd0);
        cyc(); Reset = 1'b0;
        // Write addr 0x005 len 12: bursts 3, 8, 1
        cyc(); req(1'b1, 1'b1, 12'h005, 8'd12); #1;
        chk("t1_accept_ready", 32'(bus.req_ready), 32'd1);
        chk("t1_accept_wren", 32'(bus.WrEn), 32'd0);
        cyc(); req(1'b0, 1'b0, 12'h0, 8'd0); #1;
        push_chk("t1_p0", 16'h802A, 1'b0);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        chk("t1_ready_low", 32'(bus.req_ready), 32'd0);
        cyc(); #1; push_chk("t1_p1", 16'h8047, 1'b0);
        cyc(); #1; push_chk("t1_p2", 16'h8080, 1'b1);
        cyc(); #1;
        chk("t1_ready_back", 32'(bus.req_ready), 32'd1);
        chk("t1_idle_wren", 32'(bus.WrEn), 32'd0);
        chk("t1_idle_data", 32'(bus.Data), 32'd0);
        chk("t1_idle_done", 32'(bus.done), 32'd0);
        // Read addr 0xFFE len 4: address wraps to 0
        req(1'b1, 1'b0, 12'hFFE, 8'd4);
        cyc(); req(1'b0, 1'b0, 12'h0, 8'd0); #1;
        push_chk("t2_p0", 16'h7FF1, 1'b0);
        cyc(); #1; push_chk("t2_p1", 16'h0001, 1'b1);
        // Write addr 0 len 8 with Full high for 5 cycles
        cyc(); req(1'b1, 1'b1, 12'h000, 8'd8);
        cyc(); req(1'b0, 1'b0, 12'h0, 8'd0); bus.Full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_stall_wren", 32'(bus.WrEn), 32'd0);
            chk("t3_stall_data", 32'(bus.Data), 32'h8007);
            cyc();
        end
        bus.Full = 1'b0; #1;
        push_chk("t3_push", 16'h8007, 1'b1);
        cyc(); #1;
        chk("t3_stall_cnt", 32'(bus.stall_cnt), 32'(STALL_EXP));
        chk("t3_ready", 32'(bus.req_ready), 32'd1);
        // Zero-length request: done only, no push, never busy
        req(1'b1, 1'b1, 12'h123, 8'd0); #1;
        chk("t4_done_early", 32'(bus.done), 32'd0);
        cyc(); req(1'b0, 1'b0, 12'h0, 8'd0); #1;
        chk("t4_done", 32'(bus.done), 32'd1);
        chk("t4_busy", 32'(bus.busy), 32'd0);
        chk("t4_wren", 32'(bus.WrEn), 32'd0);
        cyc(); #1;
        chk("t4_done_once", 32'(bus.done), 32'd0);
        chk("t4_busy2", 32'(bus.busy), 32'd0);
        // Reset during second burst of a len-20 write
        req(1'b1, 1'b1, 12'h000, 8'd20);
        cyc(); req(1'b0, 1'b0, 12'h0, 8'd0); #1;
        push_chk("t5_p0", 16'h8007, 1'b0);
        cyc(); #1; push_chk("t5_p1", 16'h8047, 1'b0);
        Reset = 1'b1; #1;
        chk("t5_rst_wren", 32'(bus.WrEn), 32'd0);
        chk("t5_rst_busy", 32'(bus.busy), 32'd0);
        chk("t5_rst_ready", 32'(bus.req_ready), 32'd1);
        chk("t5_rst_data", 32'(bus.Data), 32'd0);
        chk("t5_rst_done", 32'(bus.done), 32'd0);
        chk("t5_rst_stall", 32'(bus.stall_cnt), 32'd0);
        cyc(); Reset = 1'b0;
        cyc(); req(1'b1, 1'b1, 12'h010, 8'd3);
        cyc(); req(1'b0, 1'b0, 12'h0, 8'd0); #1;
        push_chk("t5_new", 16'h8082, 1'b1);
        // Back-to-back with req_valid held high
        cyc(); req(1'b1, 1'b1, 12'h000, 8'd8);
        cyc(); req(1'b1, 1'b1, 12'h020, 8'd1); #1;
        push_chk("t6_a", 16'h8007, 1'b1);
        chk("t6_a_ready", 32'(bus.req_ready), 32'd0);
        cyc(); #1;
        chk("t6_bubble_ready", 32'(bus.req_ready), 32'd1);
        chk("t6_bubble_wren", 32'(bus.WrEn), 32'd0);
        cyc(); req(1'b0, 1'b0, 12'h0, 8'd0); #1;
        push_chk("t6_b", 16'h8100, 1'b1);
        // Random Full toggling: write addr 3 len 30 must yield exactly five commands
        cyc(); req(1'b1, 1'b1, 12'h003, 8'd30);
        cyc(); req(1'b0, 1'b0, 12'h0, 8'd0);
        k = 0;
        for (int i = 0; i < 80 && k < 5; i++) begin
            bus.Full = 1'($urandom_range(0, 1)); #1;
            if (bus.WrEn) begin
                chk("t7_full_low", 32'(bus.Full), 32'd0);
                chk("t7_data", 32'(bus.Data), 32'(exp_q[k]));
                chk("t7_done", 32'(bus.done), 32'(k == 4));
                k++;
            end
            cyc();
        end
        bus.Full = 1'b0; #1;
        chk("t7_count", 32'(k), 32'd5);
        chk("t7_no_extra", 32'(bus.WrEn), 32'd0);
        chk("t7_idle", 32'(bus.req_ready), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cmd_fifo_writer.md
Name: cmd_fifo_writer

Overview:
- Write-side producer for the dual-clock command FIFO (16-bit, handshake style). Runs in the WrClk domain.
- Accepts variable-length transfer requests from the local master over a valid/ready handshake.
- Splits each request into aligned bursts of at most MAX_BURST beats and pushes one command word per burst into the FIFO, honouring Full.
- The memory-side controller drains the FIFO on RdClk.

Parameters:
- WIDTH, 16, command word width; must equal 1+ADDR_W+LEN_W (elaboration error otherwise)
- ADDR_W, 12, beat address width
- LEN_W, 3, burst length field width; field value = beats-1
- MAX_BURST, 8, max beats per command; power of two, ≤ 2^LEN_W
- REQ_LEN_W, 8, request length width in beats

Ports:
- WrClk  input  1  clock
- Reset  input  1  reset, asynchronous, active-high
- req_valid  input  1  request valid
- req_ready  output  1  request accepted when valid&&ready
- req_wr  input  1  1 = write command, 0 = read command
- req_addr  input  ADDR_W  start beat address
- req_len  input  REQ_LEN_W  total beats; 0 = no-op
- busy  output  1  request in progress
- done  output  1  one-cycle pulse on the last command push
- WrEn  output  1  FIFO write enable
- Data  output  WIDTH  FIFO command word
- Full  input  1  FIFO full (WrClk domain)
- stall_cnt  output  16  Full-stall cycle count (optional feature)

Behaviour:
- Reset values (while Reset high): state IDLE, req_ready=1, busy=0, done=0, WrEn=0, Data=0, stall_cnt=0. Internal cur_addr, remaining and op are cleared.
- States: IDLE, SEND.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch op=req_wr, cur_addr=req_addr, remaining=req_len.
  - If req_len≠0, go to SEND.
  - If req_len=0, stay in IDLE, pulse done next cycle, push nothing.
- SEND:
  - req_ready=0, busy=1.
  - chunk = min(remaining, MAX_BURST − (cur_addr mod MAX_BURST)), computed combinationally.
  - Data = {op, cur_addr, chunk−1}: op in bit WIDTH−1, address in the next ADDR_W bits, length field in the low LEN_W bits.
  - Data is driven only in SEND and holds 0 in IDLE.
  - WrEn = SEND && !Full. The block never asserts WrEn while Full=1, so every asserted WrEn is a real push.
  - On each push: cur_addr += chunk, modulo 2^ADDR_W (address wraps silently); remaining −= chunk.
  - If chunk == remaining: the push is the last one; done pulses in the same cycle as that WrEn, and the state returns to IDLE.
- Latency:
  - Request accepted in cycle N → first WrEn no earlier than N+1.
  - Consecutive chunks push on consecutive cycles when Full=0.
  - After the last push, req_ready rises the next cycle: one bubble between requests.
- Full held high: Data, cur_addr and remaining are frozen; resumes the cycle after Full falls.
- Full rising in a cycle: WrEn deasserts in that same cycle; no data is lost.
- Reset mid-request: immediate abort to IDLE, WrEn drops asynchronously, the partial request is discarded and no done pulse is issued.
- req_valid while busy: ignored (req_ready=0); the master holds it.

Optional Feature:
- Macro CMD_FIFO_WRITER_STALL_CNT_EN.
- Defined: stall_cnt increments on every WrClk cycle with state SEND && Full=1. It saturates at 16'hFFFF and clears only on Reset.
- Undefined: stall_cnt tied to 0 and no counter logic is inferred.

Test Plan:
- Write request, addr 0x005, len 12, Full=0 → three consecutive pushes: Data 0x802A, 0x8047, 0x8080. done pulses with the third push; req_ready returns the cycle after.
- Read request, addr 0xFFE, len 4 → pushes 0x7FF1 then 0x0001 (address wrap).
- Write request, addr 0x000, len 8, Full high for 5 cycles starting at cycle N+1 → WrEn=0 and Data=0x8007 stable for 5 cycles. Single push on the 6th cycle; stall_cnt=5 with the macro, 0 without.
- Request with len 0 → no WrEn; done pulses once; busy never asserts.
- Reset asserted mid-request during the second chunk of a len-20 write → WrEn=0 immediately, all outputs at reset values. A new request after deassert is processed from its own start address.
- Back-to-back requests, req_valid held high → exactly one idle cycle between the last push of request A and the acceptance of request B. Every WrEn observed only with Full=0; Full toggling randomly causes no lost or duplicated commands.
